clock_set_controller: RTL and testbench

- Front-panel time-set sequencer for the 24 h seconds-of-day clock counter.
- Uses three buttons (mode/up/down) to freeze the running counter, edit hours, minutes and seconds, then load the edited value back as a 17-bit seconds-of-day count.
- Drives the counter's run-enable and load, plus a per-digit blank mask so the six 7-segment digits can blink the field being edited.

---
 rtl/clock_set_controller.sv | 216 +++++++++++++++++++++
 tb/tb_clock_set_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// Front-panel time-set sequencer: freezes the seconds-of-day counter, edits HH/MM/SS, loads it back.
// Optional idle-timeout abandon of an edit is enabled by defining CLOCK_SET_TIMEOUT_EN.
module clock_set_controller #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BLINK_DIV   = 25_000_000,
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [16:0] cur_seconds,
    output logic        run_en,
    output logic        load,
    output logic [16:0] load_value,
    output logic [16:0] disp_seconds,
    output logic [1:0]  edit_field,
    output logic [5:0]  blank_mask
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HOUR,
        ST_SET_MIN,
        ST_SET_SEC,
        ST_COMMIT
    } state_t;

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_t        r_state;
    logic          r_mode_q;
    logic          r_up_q;
    logic          r_down_q;
    logic [4:0]    r_edit_h;
    logic [5:0]    r_edit_m;
    logic [5:0]    r_edit_s;
    logic          r_run_en;
    logic          r_load;
    logic [16:0]   r_load_value;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;

    logic          w_mode_p;
    logic          w_up_p;
    logic          w_down_p;
    logic          w_in_set;
    logic          w_adjust;
    logic          w_blink_clr;
    logic          w_timeout;
    logic          w_in_range;
    logic [16:0]   w_min_total;
    logic [4:0]    w_cap_h;
    logic [5:0]    w_cap_m;
    logic [5:0]    w_cap_s;
    logic [16:0]   w_packed;

    assign w_mode_p    = btn_mode & ~r_mode_q;
    assign w_up_p      = btn_up & ~r_up_q;
    assign w_down_p    = btn_down & ~r_down_q;
    assign w_in_set    = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN) ||
                         (r_state == ST_SET_SEC);
    // Mode outranks up/down; up and down together cancel out.
    assign w_adjust    = w_in_set & ~w_mode_p & (w_up_p ^ w_down_p);
    assign w_blink_clr = ((r_state == ST_RUN) & w_mode_p) |
                         (w_in_set & (w_mode_p | w_up_p | w_down_p));

    assign w_in_range  = (cur_seconds < 17'd86400);
    assign w_min_total = cur_seconds / 17'd60;
    assign w_cap_h     = w_in_range ? 5'(cur_seconds / 17'd3600) : 5'd0;
    assign w_cap_m     = w_in_range ? 6'(w_min_total % 17'd60) : 6'd0;
    assign w_cap_s     = w_in_range ? 6'(cur_seconds % 17'd60) : 6'd0;
    assign w_packed    = 17'(r_edit_h) * 17'd3600 + 17'(r_edit_m) * 17'd60 + 17'(r_edit_s);

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SW = (TIMEOUT_SEC > 0) ? $clog2(TIMEOUT_SEC + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SEC_LAST = SW'(TIMEOUT_SEC - 1);

    logic [PW-1:0] r_pre;
    logic [SW-1:0] r_idle_sec;

    always_ff @(posedge clk) begin
        if (reset || !w_in_set || w_blink_clr) begin
            r_pre      <= '0;
            r_idle_sec <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre      <= '0;
            r_idle_sec <= r_idle_sec + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_timeout = w_in_set & ~w_blink_clr & (r_pre == PRE_LAST) & (r_idle_sec == SEC_LAST);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (CLK_HZ == 0) || (TIMEOUT_SEC == 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_mode_q     <= 1'b1;
            r_up_q       <= 1'b1;
            r_down_q     <= 1'b1;
            r_edit_h     <= '0;
            r_edit_m     <= '0;
            r_edit_s     <= '0;
            r_run_en     <= 1'b1;
            r_load       <= 1'b0;
            r_load_value <= '0;
        end else begin
            r_mode_q <= btn_mode;
            r_up_q   <= btn_up;
            r_down_q <= btn_down;
            r_load   <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_mode_p) begin
                        r_edit_h <= w_cap_h;
                        r_edit_m <= w_cap_m;
                        r_edit_s <= w_cap_s;
                        r_run_en <= 1'b0;
                        r_state  <= ST_SET_HOUR;
                    end
                end
                ST_SET_HOUR: begin
                    if (w_mode_p) begin
                        r_state <= ST_SET_MIN;
                    end else if (w_timeout) begin
                        r_run_en <= 1'b1;
                        r_state  <= ST_RUN;
                    end else if (w_adjust) begin
                        if (w_up_p) r_edit_h <= (r_edit_h == 5'd23) ? 5'd0 : r_edit_h + 5'd1;
                        else        r_edit_h <= (r_edit_h == 5'd0) ? 5'd23 : r_edit_h - 5'd1;
                    end
                end
                ST_SET_MIN: begin
                    if (w_mode_p) begin
                        r_state <= ST_SET_SEC;
                    end else if (w_timeout) begin
                        r_run_en <= 1'b1;
                        r_state  <= ST_RUN;
                    end else if (w_adjust) begin
                        if (w_up_p) r_edit_m <= (r_edit_m == 6'd59) ? 6'd0 : r_edit_m + 6'd1;
                        else        r_edit_m <= (r_edit_m == 6'd0) ? 6'd59 : r_edit_m - 6'd1;
                    end
                end
                ST_SET_SEC: begin
                    if (w_mode_p) begin
                        r_load       <= 1'b1;
                        r_load_value <= w_packed;
                        r_run_en     <= 1'b1;
                        r_state      <= ST_COMMIT;
                    end else if (w_timeout) begin
                        r_run_en <= 1'b1;
                        r_state  <= ST_RUN;
                    end else if (w_adjust) begin
                        if (w_up_p) r_edit_s <= (r_edit_s == 6'd59) ? 6'd0 : r_edit_s + 6'd1;
                        else        r_edit_s <= (r_edit_s == 6'd0) ? 6'd59 : r_edit_s - 6'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Blink restarts on field entry and on every adjust so the edited digits stay lit while changing.
    always_ff @(posedge clk) begin
        if (reset || !w_in_set || w_blink_clr) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_comb begin
        edit_field = 2'd0;
        blank_mask = 6'b000000;
        case (r_state)
            ST_SET_HOUR: begin
                edit_field      = 2'd1;
                blank_mask[5:4] = {2{r_phase}};
            end
            ST_SET_MIN: begin
                edit_field      = 2'd2;
                blank_mask[3:2] = {2{r_phase}};
            end
            ST_SET_SEC: begin
                edit_field      = 2'd3;
                blank_mask[1:0] = {2{r_phase}};
            end
            default: begin
                edit_field = 2'd0;
                blank_mask = 6'b000000;
            end
        endcase
    end

    assign disp_seconds = w_in_set ? w_packed : cur_seconds;
    assign run_en       = r_run_en;
    assign load         = r_load;
    assign load_value   = r_load_value;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with a short blink period and small timeout settings.
module tb_clock_set_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_mode;
    logic        btn_up;
    logic        btn_down;
    logic [16:0] cur_seconds;
    logic        run_en;
    logic        load;
    logic [16:0] load_value;
    logic [16:0] disp_seconds;
    logic [1:0]  edit_field;
    logic [5:0]  blank_mask;

    int checks = 0;
    int fails  = 0;
    int n_load;
    int n_bad;

    always #5 clk = ~clk;

    clock_set_controller #(
        .CLK_HZ     (10),
        .BLINK_DIV  (4),
        .TIMEOUT_SEC(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .cur_seconds (cur_seconds),
        .run_en      (run_en),
        .load        (load),
        .load_value  (load_value),
        .disp_seconds(disp_seconds),
        .edit_field  (edit_field),
        .blank_mask  (blank_mask)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One idle cycle so the history regs see 0, then a one-cycle press.
    task automatic press(input logic m, input logic u, input logic d);
        tick(1);
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        tick(1);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        btn_mode    = 1'b1;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        cur_seconds = 17'd45296;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_run_en", run_en, 1);
        check("rst_load", load, 0);
        check("rst_load_value", load_value, 0);
        check("rst_edit_field", edit_field, 0);
        check("rst_blank", blank_mask, 0);
        check("rst_disp", disp_seconds, 45296);

        btn_mode = 1'b0;
        n_load = 0;
        n_bad  = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (load !== 1'b0) n_load++;
            if (edit_field !== 2'd0 || run_en !== 1'b1 || blank_mask !== 6'd0) n_bad++;
        end
        check("held_mode_load_pulses", n_load, 0);
        check("held_mode_bad_cycles", n_bad, 0);

        // 12:34:56 round trip
        press(1, 0, 0);
        check("enter_edit_field", edit_field, 1);
        check("enter_run_en", run_en, 0);
        check("enter_disp", disp_seconds, 45296);
        cur_seconds = 17'd100;
        tick(1);
        check("frozen_disp", disp_seconds, 45296);
        press(1, 0, 0);
        check("to_min_field", edit_field, 2);
        press(1, 0, 0);
        check("to_sec_field", edit_field, 3);
        press(1, 0, 0);
        check("commit_load", load, 1);
        check("commit_value", load_value, 45296);
        check("commit_run_en", run_en, 1);
        check("commit_field", edit_field, 0);
        tick(1);
        check("post_commit_load", load, 0);
        check("post_commit_value", load_value, 45296);
        check("post_commit_run_en", run_en, 1);
        check("post_commit_disp", disp_seconds, 100);

        // 23:34:56: hour wrap both ways, minute up, up+down cancel, second up
        cur_seconds = 17'd84896;
        press(1, 0, 0);
        check("h23_disp", disp_seconds, 84896);
        press(0, 1, 0);
        check("h_wrap_up", disp_seconds, 2096);
        press(0, 0, 1);
        check("h_wrap_down", disp_seconds, 84896);
        press(1, 0, 0);
        check("h23_to_min", edit_field, 2);
        press(0, 1, 0);
        check("m_up", disp_seconds, 84956);
        press(1, 0, 0);
        check("m_to_sec", edit_field, 3);
        press(0, 1, 1);
        check("updown_cancel", disp_seconds, 84956);
        press(0, 1, 0);
        check("s_up", disp_seconds, 84957);
        press(1, 0, 0);
        check("commit2_load", load, 1);
        check("commit2_value", load_value, 84957);

        // 05:00:07: mode beats up, minute wrap down, blink timing
        cur_seconds = 17'd18007;
        press(1, 0, 0);
        check("h5_field", edit_field, 1);
        press(1, 1, 0);
        check("mode_wins_field", edit_field, 2);
        check("mode_wins_disp", disp_seconds, 18007);
        press(0, 0, 1);
        check("m_wrap_down", disp_seconds, 21547);
        check("blink_k0", blank_mask, 6'b000000);
        tick(3);
        check("blink_k3", blank_mask, 6'b000000);
        tick(1);
        check("blink_k4", blank_mask, 6'b001100);
        tick(3);
        check("blink_k7", blank_mask, 6'b001100);
        tick(1);
        check("blink_k8", blank_mask, 6'b000000);
        tick(4);
        check("blink_k12", blank_mask, 6'b001100);
        press(0, 1, 0);
        check("m_wrap_up", disp_seconds, 18007);
        check("blink_up_clear", blank_mask, 6'b000000);
        tick(3);
        check("blink_restart_k3", blank_mask, 6'b000000);
        tick(1);
        check("blink_restart_k4", blank_mask, 6'b001100);
        press(1, 0, 0);
        press(1, 0, 0);
        check("commit3_load", load, 1);
        check("commit3_value", load_value, 18007);
        tick(1);

        // out-of-range capture, then reset mid-edit
        cur_seconds = 17'd90000;
        press(1, 0, 0);
        check("oor_disp", disp_seconds, 0);
        press(0, 1, 0);
        check("oor_h_up", disp_seconds, 3600);
        reset = 1'b1;
        tick(1);
        check("midedit_rst_run_en", run_en, 1);
        check("midedit_rst_field", edit_field, 0);
        check("midedit_rst_load", load, 0);
        check("midedit_rst_blank", blank_mask, 0);
        reset = 1'b0;

        // up ignored in RUN
        cur_seconds = 17'd1000;
        press(0, 1, 0);
        check("run_up_field", edit_field, 0);
        check("run_up_disp", disp_seconds, 1000);
        press(1, 0, 0);
        check("run_up_capture", disp_seconds, 1000);

        // idle in SET_HOUR
        n_load = 0;
        for (int i = 0; i < 22; i++) begin
            tick(1);
            if (load !== 1'b0) n_load++;
        end
        check("idle_no_load", n_load, 0);
`ifdef CLOCK_SET_TIMEOUT_EN
        check("timeout_field", edit_field, 0);
        check("timeout_run_en", run_en, 1);
        check("timeout_disp", disp_seconds, 1000);
`else
        check("no_timeout_field", edit_field, 1);
        check("no_timeout_run_en", run_en, 0);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
